// File: rtl/riscv_core_pkg.sv
// Shared definitions for the 3-stage RISC-V core: reset vector, NOP encoding,
// the BIOS address-region nibble and the fetch-stage state encoding.
package riscv_core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [3:0]  BIOS_REGION      = 4'h4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    function automatic logic isBiosAddr(input logic [31:0] addr);
        return addr[31:28] == BIOS_REGION;
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_pc_gen.sv
// PC register, next-PC priority mux and the registered BIOS/IMEM region select
// that lines up with the 1-cycle synchronous memory read.
module riscv_fetch_stage_pc_gen
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectTarget,
    input  logic        i_holdPc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcNext,
    output logic        o_srcBios
);

    logic [31:0] r_pc;
    logic        r_srcBios;
    logic [31:0] w_pcNext;
    logic [31:0] w_target;

    // Word alignment: the two low target bits never reach the PC.
    assign w_target = i_redirectTarget & 32'hFFFF_FFFC;

    always_comb begin
        w_pcNext = r_pc + 32'd4;
        if (i_redirect) begin
            w_pcNext = w_target;
        end else if (i_holdPc) begin
            w_pcNext = r_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_srcBios <= 1'b1;
        end else begin
            r_pc      <= w_pcNext;
            r_srcBios <= isBiosAddr(w_pcNext);
        end
    end

    assign o_pc      = r_pc;
    assign o_pcNext  = w_pcNext;
    assign o_srcBios = r_srcBios;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Fetch stage: boot/run/stall sequencing, redirect kill, load-use replay
// register and the delivered-instruction counter.
module riscv_fetch_stage
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               hold,
    output logic [BIOS_AW-1:0] bios_addr,
    input  logic [31:0]        bios_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        pc_fetch,
    output logic [31:0]        inst_fetch,
    output logic               inst_valid,
    output logic               flush,
    output logic [31:0]        fetch_count
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_holdInst;
    logic [31:0]  r_fetchCount;
    logic [31:0]  w_pc;
    logic [31:0]  w_pcNext;
    logic         w_srcBios;
    logic [31:0]  w_instRaw;
    logic [31:0]  w_inst;
    logic         w_valid;
    logic         w_holdPc;
    logic         w_runHold;
    logic         w_captureHold;
    logic         w_countEn;

    // Hold only matters in RUN; decode never holds twice in a row.
    assign w_runHold     = (r_state == RUN) && hold;
    assign w_holdPc      = (r_state == BOOT) || w_runHold;
    assign w_captureHold = w_runHold && !redirect;
    assign w_countEn     = w_valid && !w_runHold;

    riscv_fetch_stage_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pcGen (
        .clk             (clk),
        .rst             (rst),
        .i_redirect      (redirect),
        .i_redirectTarget(redirect_target),
        .i_holdPc        (w_holdPc),
        .o_pc            (w_pc),
        .o_pcNext        (w_pcNext),
        .o_srcBios       (w_srcBios)
    );

    assign w_instRaw = w_srcBios ? bios_dout : imem_dout;

    always_comb begin
        w_stateNext = r_state;
        w_inst      = NOP;
        w_valid     = 1'b0;
        case (r_state)
            BOOT: begin
                w_stateNext = RUN;
            end
            RUN: begin
                w_inst  = w_instRaw;
                w_valid = 1'b1;
                if (hold) begin
                    w_stateNext = STALL;
                end
            end
            STALL: begin
                w_inst      = r_holdInst;
                w_valid     = 1'b1;
                w_stateNext = RUN;
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
        // A resolved branch kills whatever fetch is showing this cycle.
        if (redirect) begin
            w_stateNext = RUN;
            w_inst      = NOP;
            w_valid     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_holdInst   <= NOP;
            r_fetchCount <= 32'd0;
        end else begin
            r_state <= w_stateNext;
            if (w_captureHold) begin
                r_holdInst <= w_instRaw;
            end
            if (w_countEn) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
        end
    end

    assign bios_addr   = w_pcNext[BIOS_AW+1:2];
    assign imem_addr   = w_pcNext[IMEM_AW+1:2];
    assign pc_fetch    = w_pc;
    assign inst_fetch  = w_inst;
    assign inst_valid  = w_valid;
    assign flush       = redirect;
    assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage with BIOS/IMEM models and an
// expected-output queue filled per scenario.
module tb_riscv_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOPI   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        flush;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        hold;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] pc_fetch;
    logic [31:0] inst_fetch;
    logic        inst_valid;
    logic        flush;
    logic [31:0] fetch_count;

    logic [31:0] biosMem [0:4095];
    logic [31:0] imemMem [0:16383];
    exp_t        sb [$];
    int          total;
    int          bad;

    riscv_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .hold           (hold),
        .bios_addr      (bios_addr),
        .bios_dout      (bios_dout),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .pc_fetch       (pc_fetch),
        .inst_fetch     (inst_fetch),
        .inst_valid     (inst_valid),
        .flush          (flush),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] biosWord(input int unsigned i);
        if (i == 0) return 32'h0000_0093;
        return 32'hB000_0000 | i;
    endfunction

    function automatic logic [31:0] imemWord(input int unsigned i);
        if (i == 16) return 32'h0050_0113;
        return 32'hC000_0000 | i;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        bios_dout <= biosMem[bios_addr];
        imem_dout <= imemMem[imem_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] tg, input logic hd);
        @(negedge clk);
        rst             = r;
        redirect        = rd;
        redirect_target = tg;
        hold            = hd;
        #1;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [11:0] addrs [3] = '{12'd0, 12'd1, 12'd2};
        rst = 1'b1; redirect = 1'b0; redirect_target = 32'h0; hold = 1'b0;
        #3;
        total += 5;
        if (pc_fetch !== RST_PC) begin bad++; $display("[TB] FAIL reset pc: got %h want %h", pc_fetch, RST_PC); end
        if (inst_fetch !== NOPI) begin bad++; $display("[TB] FAIL reset inst: got %h want %h", inst_fetch, NOPI); end
        if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset valid: got %b want 0", inst_valid); end
        if (flush !== 1'b0) begin bad++; $display("[TB] FAIL reset flush: got %b want 0", flush); end
        if (fetch_count !== 32'd0) begin bad++; $display("[TB] FAIL reset count: got %0d want 0", fetch_count); end
        @(negedge clk);
        @(negedge clk);
        sb.push_back('{RST_PC, NOPI, 1'b0, 1'b0});
        sb.push_back('{RST_PC, biosWord(0), 1'b1, 1'b0});
        sb.push_back('{RST_PC + 32'd4, biosWord(1), 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            e = sb.pop_front();
            total += 5;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL boot pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL boot inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL boot valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (flush !== e.flush) begin bad++; $display("[TB] FAIL boot flush step %0d: got %b want %b", i, flush, e.flush); end
            if (bios_addr !== addrs[i]) begin bad++; $display("[TB] FAIL boot bios_addr step %0d: got %0d want %0d", i, bios_addr, addrs[i]); end
        end
    endtask

    task automatic test_hold();
        exp_t        e;
        logic        hd  [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] cnt [3] = '{32'd2, 32'd2, 32'd3};
        sb.push_back('{32'h4000_0008, biosWord(2), 1'b1, 1'b0});
        sb.push_back('{32'h4000_0008, biosWord(2), 1'b1, 1'b0});
        sb.push_back('{32'h4000_000C, biosWord(3), 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, hd[i]);
            e = sb.pop_front();
            total += 5;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL hold pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL hold inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL hold valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (flush !== e.flush) begin bad++; $display("[TB] FAIL hold flush step %0d: got %b want %b", i, flush, e.flush); end
            if (fetch_count !== cnt[i]) begin bad++; $display("[TB] FAIL hold count step %0d: got %0d want %0d", i, fetch_count, cnt[i]); end
        end
        hold = 1'b0;
    endtask

    task automatic test_redirect();
        exp_t        e;
        logic        rd  [2] = '{1'b1, 1'b0};
        logic [31:0] cnt [2] = '{32'd4, 32'd4};
        sb.push_back('{32'h4000_0010, NOPI, 1'b0, 1'b1});
        sb.push_back('{32'h1000_0040, 32'h0050_0113, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, rd[i], 32'h1000_0040, 1'b0);
            e = sb.pop_front();
            total += 5;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL redirect pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL redirect inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL redirect valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (flush !== e.flush) begin bad++; $display("[TB] FAIL redirect flush step %0d: got %b want %b", i, flush, e.flush); end
            if (fetch_count !== cnt[i]) begin bad++; $display("[TB] FAIL redirect count step %0d: got %0d want %0d", i, fetch_count, cnt[i]); end
            if (i == 0) begin
                total++;
                if (imem_addr !== 14'd16) begin bad++; $display("[TB] FAIL redirect imem_addr: got %0d want 16", imem_addr); end
            end
        end
    endtask

    task automatic test_redirect_hold();
        exp_t        e;
        logic        rd  [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] cnt [3] = '{32'd5, 32'd5, 32'd6};
        sb.push_back('{32'h1000_0044, NOPI, 1'b0, 1'b1});
        sb.push_back('{32'h4000_0020, biosWord(8), 1'b1, 1'b0});
        sb.push_back('{32'h4000_0024, biosWord(9), 1'b1, 1'b0});
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, rd[i], 32'h4000_0020, rd[i]);
            e = sb.pop_front();
            total += 5;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL redir_hold pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL redir_hold inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL redir_hold valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (flush !== e.flush) begin bad++; $display("[TB] FAIL redir_hold flush step %0d: got %b want %b", i, flush, e.flush); end
            if (fetch_count !== cnt[i]) begin bad++; $display("[TB] FAIL redir_hold count step %0d: got %0d want %0d", i, fetch_count, cnt[i]); end
        end
    endtask

    task automatic test_align_wrap();
        exp_t        e;
        logic        rd [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] tg [5] = '{32'h1000_0043, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0};
        sb.push_back('{32'h4000_0028, NOPI, 1'b0, 1'b1});
        sb.push_back('{32'h1000_0040, imemWord(16), 1'b1, 1'b0});
        sb.push_back('{32'h1000_0044, NOPI, 1'b0, 1'b1});
        sb.push_back('{32'hFFFF_FFFC, imemWord(16383), 1'b1, 1'b0});
        sb.push_back('{32'h0000_0000, imemWord(0), 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, rd[i], tg[i], 1'b0);
            e = sb.pop_front();
            total += 4;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL align_wrap pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL align_wrap inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL align_wrap valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (flush !== e.flush) begin bad++; $display("[TB] FAIL align_wrap flush step %0d: got %b want %b", i, flush, e.flush); end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        logic hd [2] = '{1'b1, 1'b0};
        sb.push_back('{32'h0000_0004, imemWord(1), 1'b1, 1'b0});
        sb.push_back('{32'h0000_0004, imemWord(1), 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, hd[i]);
            e = sb.pop_front();
            total += 3;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL stall pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL stall inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL stall valid step %0d: got %b want %b", i, inst_valid, e.valid); end
        end
        rst = 1'b1;
        #1;
        total += 4;
        if (pc_fetch !== RST_PC) begin bad++; $display("[TB] FAIL midrst pc: got %h want %h", pc_fetch, RST_PC); end
        if (inst_fetch !== NOPI) begin bad++; $display("[TB] FAIL midrst inst: got %h want %h", inst_fetch, NOPI); end
        if (inst_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst valid: got %b want 0", inst_valid); end
        if (fetch_count !== 32'd0) begin bad++; $display("[TB] FAIL midrst count: got %0d want 0", fetch_count); end
        sb.push_back('{RST_PC, NOPI, 1'b0, 1'b0});
        sb.push_back('{RST_PC, biosWord(0), 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            e = sb.pop_front();
            total += 4;
            if (pc_fetch !== e.pc) begin bad++; $display("[TB] FAIL restart pc step %0d: got %h want %h", i, pc_fetch, e.pc); end
            if (inst_fetch !== e.inst) begin bad++; $display("[TB] FAIL restart inst step %0d: got %h want %h", i, inst_fetch, e.inst); end
            if (inst_valid !== e.valid) begin bad++; $display("[TB] FAIL restart valid step %0d: got %b want %b", i, inst_valid, e.valid); end
            if (fetch_count !== 32'd0) begin bad++; $display("[TB] FAIL restart count step %0d: got %0d want 0", i, fetch_count); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) biosMem[i] = biosWord(i);
        for (int i = 0; i < 16384; i++) imemMem[i] = imemWord(i);
        test_reset();
        test_hold();
        test_redirect();
        test_redirect_hold();
        test_align_wrap();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
